i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- Synthesizable I2C target (responder) for the far end of the bus driven by the I2C master.
- Supports a 7-bit device address, an 8-bit register address, 8-bit data and auto-increment. This matches the D7R8 single and burst (_CONT) transactions.
- Holds a local byte register file. A side port lets the SoC or bench peek at the contents.
- Oversamples SCL/SDA on the system clock. Usable as an on-chip test target and as the bench I2C device model.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address this target answers to.
- DEPTH, 16, number of byte registers; power of 2, range 2..256.
- FILT, 2, number of consecutive equal samples required before SCL/SDA are accepted (glitch filter).

Ports:
- axil_aclk  input  1  system clock; must be at least 16x the SCL rate.
- axil_aresetn  input  1  synchronous active-low reset.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release.
- peek_addr  input  8  side-port register index; only low log2(DEPTH) bits are used.
- peek_data  output  8  combinational read of regfile[peek_addr].
- busy  output  1  1 from an address-matched START until STOP or mismatch.
- wr_strobe  output  1  one-cycle pulse per byte written into the regfile.

Behaviour:
- Reset values: sda_oe=0, busy=0, wr_strobe=0, state=IDLE, reg pointer=0. Regfile contents are cleared to 0.
- Reset mid-transfer releases SDA on the next clock edge. No bus state survives reset.
- Input conditioning:
  - 2-flop synchronizer, then the FILT-sample filter, giving filtered scl and sda.
  - Edge detect produces scl_rise and scl_fall.
  - START = sda falls while scl=1. STOP = sda rises while scl=1.
  - START and STOP take precedence over data bits in the same cycle.
- Bit timing:
  - Data is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, never while scl=1.
- States:
  - IDLE: wait for START, then go to DEV.
  - DEV: shift 8 bits. On the 8th rise, compare [7:1] with DEV_ADDR.
    - Match: go to DEV_ACK and set busy=1.
    - Mismatch: go to IDLE with sda_oe=0 (no ACK).
  - DEV_ACK: assert sda_oe on the next scl_fall and release it on the following scl_fall.
    - R/W=0: go to REGA.
    - R/W=1: go to RD (first read byte loaded from regfile[ptr]).
  - REGA: shift 8 bits. Then ptr = byte mod DEPTH and go to REGA_ACK (ACK always).
  - REGA_ACK: after the ACK, go to WR.
  - WR: shift 8 bits. On the 8th rise, write regfile[ptr], pulse wr_strobe, then ptr=(ptr+1) mod DEPTH. Go to WR_ACK (ACK always), then back to WR.
  - RD:
    - Drive sda_oe = ~bit, MSB first, each bit set on scl_fall. The first bit is set on the scl_fall ending DEV_ACK.
    - After bit 0, release SDA, set ptr=(ptr+1) mod DEPTH, go to RD_ACK.
  - RD_ACK: sample the master's bit on scl_rise.
    - 0 (ACK): go to RD with the next byte.
    - 1 (NACK): go to WAIT, SDA released.
  - WAIT: ignore bits until START or STOP.
- Repeated START in any state: go to DEV, ptr retained. This is how a read after a reg-addr write works.
- STOP in any state: go to IDLE, busy=0, sda_oe=0.
- Pointer wrap: a burst past DEPTH-1 continues at index 0.
- A general call (address 0) is not acknowledged.
- Simultaneous peek during a write: peek_data shows the old value until the clock edge of the write.

Test Plan:
- Single write: START, 0xA0, 0x03, 0x5A, STOP -> three ACKs, wr_strobe pulses once, peek_addr=3 gives peek_data=0x5A, busy=0 after STOP.
- Random read: START, 0xA0, 0x03, Sr, 0xA1, read byte with NACK, STOP -> SDA returns 0x5A, ACK on both address bytes, sda_oe=0 after NACK.
- Burst write/read with wrap (DEPTH=16): write 0x0E with 0x11,0x22,0x33,0x44 -> regs 14,15,0,1 hold 0x11,0x22,0x33,0x44. Burst read from 0x0E with 4 bytes (ACK,ACK,ACK,NACK) returns the same sequence.
- Address mismatch: START, 0xA2 (addr 0x51) -> no ACK, sda_oe stays 0 for the whole transfer, busy stays 0, regfile unchanged.
- Glitch and reset: a 1-clock SCL glitch mid-byte is ignored (byte still 0x5A). Asserting axil_aresetn=0 during a read data bit makes sda_oe=0 on the next clock and peek_data=0 for all indices.
- Back-to-back traffic: the D7R8 and D7R8_CONT master sequences (10 single, 5x4 burst) give 0 mismatches.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a 7-bit device address, 8-bit register pointer and a local
// byte register file. SCL/SDA are oversampled on axil_aclk, synchronized and
// glitch-filtered. Writes and reads auto-increment the pointer with wrap.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         FILT     = 2
) (
    input  logic       axil_aclk,
    input  logic       axil_aresetn,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] peek_addr,
    output logic [7:0] peek_data,
    output logic       busy,
    output logic       wr_strobe
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_REGA, S_REGA_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT
    } state_t;

    logic [1:0]      scl_sy, sda_sy;
    logic [FILT-1:0] scl_h, sda_h;
    logic            scl_f, sda_f, scl_d, sda_d;
    logic            scl_rise, scl_fall, start_c, stop_c;

    state_t          state;
    logic [7:0]      shreg, txb;
    logic [3:0]      bitcnt;
    logic [AW-1:0]   ptr;
    logic            rnw, ack_ph;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      rx_byte;

    // Synchronize pads, accept a new level only after FILT equal samples
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            scl_sy <= 2'b11;
            sda_sy <= 2'b11;
            scl_h  <= '1;
            sda_h  <= '1;
            scl_f  <= 1'b1;
            sda_f  <= 1'b1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sy <= {scl_sy[0], scl_i};
            sda_sy <= {sda_sy[0], sda_i};
            scl_h  <= (scl_h << 1) | FILT'(scl_sy[1]);
            sda_h  <= (sda_h << 1) | FILT'(sda_sy[1]);
            if (&scl_h)       scl_f <= 1'b1;
            else if (~|scl_h) scl_f <= 1'b0;
            if (&sda_h)       sda_f <= 1'b1;
            else if (~|sda_h) sda_f <= 1'b0;
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    // Bus events; START/STOP need SCL high on both sides of the SDA edge
    always_comb begin
        scl_rise = scl_f & ~scl_d;
        scl_fall = ~scl_f & scl_d;
        start_c  = scl_f & scl_d & sda_d & ~sda_f;
        stop_c   = scl_f & scl_d & ~sda_d & sda_f;
        rx_byte  = {shreg[6:0], sda_f};
    end

    assign peek_data = mem[peek_addr[AW-1:0]];

    // Protocol FSM, register file and pointer
    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            state     <= S_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            shreg     <= '0;
            txb       <= '0;
            bitcnt    <= '0;
            ptr       <= '0;
            rnw       <= 1'b0;
            ack_ph    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_c) begin
                // START or repeated START; pointer is kept for reads
                state  <= S_DEV;
                bitcnt <= '0;
                sda_oe <= 1'b0;
                ack_ph <= 1'b0;
            end else if (stop_c) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    S_DEV: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            bitcnt <= '0;
                            // general call (address 0) never matches
                            if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                                busy   <= 1'b1;
                                rnw    <= rx_byte[0];
                                ack_ph <= 1'b0;
                                state  <= S_DEV_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_DEV_ACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe <= 1'b1;
                            ack_ph <= 1'b1;
                        end else begin
                            ack_ph <= 1'b0;
                            if (rnw) begin
                                // ACK release edge also launches read bit 7
                                txb    <= mem[ptr];
                                sda_oe <= ~mem[ptr][7];
                                bitcnt <= 4'd1;
                                state  <= S_RD;
                            end else begin
                                sda_oe <= 1'b0;
                                bitcnt <= '0;
                                state  <= S_REGA;
                            end
                        end
                    end
                    S_REGA: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            ptr    <= rx_byte[AW-1:0];
                            bitcnt <= '0;
                            ack_ph <= 1'b0;
                            state  <= S_REGA_ACK;
                        end
                    end
                    S_REGA_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe <= 1'b1;
                            ack_ph <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            ack_ph <= 1'b0;
                            bitcnt <= '0;
                            state  <= S_WR;
                        end
                    end
                    S_WR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            mem[ptr]  <= rx_byte;
                            wr_strobe <= 1'b1;
                            ptr       <= ptr + AW'(1);
                            bitcnt    <= '0;
                            ack_ph    <= 1'b0;
                            state     <= S_WR_ACK;
                        end
                    end
                    S_RD: if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            ptr    <= ptr + AW'(1);
                            ack_ph <= 1'b0;
                            state  <= S_RD_ACK;
                        end else begin
                            sda_oe <= ~txb[3'd7 - bitcnt[2:0]];
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end
                    S_RD_ACK: begin
                        // ack_ph here records that the master ACKed
                        if (scl_rise) begin
                            if (sda_f) state  <= S_WAIT;
                            else       ack_ph <= 1'b1;
                        end else if (scl_fall && ack_ph) begin
                            txb    <= mem[ptr];
                            sda_oe <= ~mem[ptr][7];
                            bitcnt <= 4'd1;
                            ack_ph <= 1'b0;
                            state  <= S_RD;
                        end
                    end
                    S_IDLE, S_WAIT: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: an I2C master model drives SCL/SDA (wired-AND with the
// target's open-drain output) and checks ACKs, read data and register file.
module tb_i2c_target_regfile;
    localparam int H = 16;   // SCL half period in clocks

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] peek_addr = '0;
    logic [7:0] peek_data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [7:0] exp_mem [16];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regfile #(.DEV_ADDR(7'h50), .DEPTH(16), .FILT(2)) dut (
        .axil_aclk(clk), .axil_aresetn(rstn), .scl_i(scl), .sda_i(sda_line),
        .sda_oe(sda_oe), .peek_addr(peek_addr), .peek_data(peek_data),
        .busy(busy), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        wq(H); sda_m = 1'b0; wq(H); scl = 1'b0;
    endtask

    task automatic i2c_rstart;
        wq(H/2); sda_m = 1'b1; wq(H/2); scl = 1'b1; wq(H); sda_m = 1'b0; wq(H); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wq(H/2); sda_m = 1'b0; wq(H/2); scl = 1'b1; wq(H); sda_m = 1'b1; wq(H);
    endtask

    // gl selects a bit whose low phase gets a one-clock SCL glitch (-1: none)
    task automatic send_byte(input logic [7:0] b, input int gl, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wq(H/2); sda_m = b[i];
            if (i == gl) begin
                wq(2); scl = 1'b1; wq(1); scl = 1'b0; wq(H/2 - 3);
            end else wq(H/2);
            scl = 1'b1; wq(H); scl = 1'b0;
        end
        wq(H/2); sda_m = 1'b1; wq(H/2); scl = 1'b1; wq(H/2);
        ack = ~sda_line;
        wq(H/2); scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wq(H/2); sda_m = 1'b1; wq(H/2); scl = 1'b1; wq(H/2);
            d[i] = sda_line;
            wq(H/2); scl = 1'b0;
        end
        wq(H/2); sda_m = nack; wq(H/2); scl = 1'b1; wq(H); scl = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        peek_addr = a; #1; d = peek_data;
    endtask

    task automatic set_addr(input logic [7:0] a);
        logic ack;
        i2c_start;
        send_byte(8'hA0, -1, ack); chk("dev_wr_ack", ack, 1'b1);
        send_byte(a, -1, ack);     chk("rega_ack", ack, 1'b1);
    endtask

    task automatic wr_burst(input logic [7:0] a, input int n, input logic [7:0] base, input logic [7:0] step);
        logic ack;
        logic [7:0] d;
        set_addr(a);
        for (int j = 0; j < n; j++) begin
            d = base + 8'(j) * step;
            send_byte(d, -1, ack); chk("wr_ack", ack, 1'b1);
            exp_mem[(int'(a) + j) % 16] = d;
        end
        i2c_stop;
    endtask

    task automatic rd_burst(input logic [7:0] a, input int n);
        logic ack;
        logic [7:0] d;
        set_addr(a);
        i2c_rstart;
        send_byte(8'hA1, -1, ack); chk("dev_rd_ack", ack, 1'b1);
        for (int j = 0; j < n; j++) begin
            read_byte(j == n - 1, d);
            chk("rd_data", d, exp_mem[(int'(a) + j) % 16]);
        end
        wq(4); chk("oe_after_nack", sda_oe, 1'b0);
        i2c_stop;
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // reset state
        wq(4);
        chk("rst_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrs", wr_strobe, 1'b0);
        peek(8'd7, d); chk("rst_peek", d, 8'h00);
        rstn = 1'b1; wq(4);

        // single write 0x5A -> reg 3
        wr_cnt = 0;
        i2c_start;
        send_byte(8'hA0, -1, ack); chk("sw_dev_ack", ack, 1'b1);
        wq(2); chk("sw_busy", busy, 1'b1);
        send_byte(8'h03, -1, ack); chk("sw_reg_ack", ack, 1'b1);
        send_byte(8'h5A, -1, ack); chk("sw_dat_ack", ack, 1'b1);
        i2c_stop;
        exp_mem[3] = 8'h5A;
        chk("sw_strobes", wr_cnt, 1);
        peek(8'd3, d); chk("sw_peek3", d, 8'h5A);
        chk("sw_busy_stop", busy, 1'b0);

        // random read of reg 3
        rd_burst(8'h03, 1);

        // burst write/read across the wrap point
        wr_cnt = 0;
        wr_burst(8'h0E, 4, 8'h11, 8'h11);
        chk("bw_strobes", wr_cnt, 4);
        peek(8'd14, d); chk("bw_peek14", d, 8'h11);
        peek(8'd15, d); chk("bw_peek15", d, 8'h22);
        peek(8'd0, d);  chk("bw_peek0", d, 8'h33);
        peek(8'd1, d);  chk("bw_peek1", d, 8'h44);
        rd_burst(8'h0E, 4);

        // address mismatch and general call: never ACKed, nothing driven
        oe_seen = 1'b0; wr_cnt = 0;
        i2c_start;
        send_byte(8'hA2, -1, ack); chk("mm_ack", ack, 1'b0);
        chk("mm_busy", busy, 1'b0);
        send_byte(8'h03, -1, ack); chk("mm_ack2", ack, 1'b0);
        i2c_stop;
        i2c_start;
        send_byte(8'h00, -1, ack); chk("gc_ack", ack, 1'b0);
        i2c_stop;
        chk("mm_oe_seen", oe_seen, 1'b0);
        chk("mm_strobes", wr_cnt, 0);
        peek(8'd3, d); chk("mm_peek3", d, 8'h5A);

        // one-clock SCL glitch inside the data byte
        i2c_start;
        send_byte(8'hA0, -1, ack); chk("gl_dev_ack", ack, 1'b1);
        send_byte(8'h05, -1, ack); chk("gl_reg_ack", ack, 1'b1);
        send_byte(8'h5A, 3, ack);  chk("gl_dat_ack", ack, 1'b1);
        i2c_stop;
        exp_mem[5] = 8'h5A;
        peek(8'd5, d); chk("gl_peek5", d, 8'h5A);

        // back-to-back single and burst traffic
        for (int i = 0; i < 10; i++) wr_burst(8'(i), 1, 8'h30 + 8'(i * 7), 8'h00);
        for (int i = 0; i < 10; i++) rd_burst(8'(i), 1);
        for (int k = 0; k < 5; k++) wr_burst(8'(k * 3 + 1), 4, 8'(k * 16 + 1), 8'h11);
        for (int k = 0; k < 5; k++) rd_burst(8'(k * 3 + 1), 4);
        for (int i = 0; i < 16; i++) begin
            peek(8'(i), d); chk("b2b_peek", d, exp_mem[i]);
        end

        // reset while the target drives a read data bit low
        wr_burst(8'h03, 1, 8'h5A, 8'h00);
        set_addr(8'h03);
        i2c_rstart;
        send_byte(8'hA1, -1, ack); chk("rr_dev_ack", ack, 1'b1);
        wq(8); chk("rr_oe_bit7", sda_oe, 1'b1);
        rstn = 1'b0;
        wq(1);
        chk("rr_oe_rst", sda_oe, 1'b0);
        chk("rr_busy_rst", busy, 1'b0);
        for (int i = 0; i < 16; i++) begin
            peek(8'(i), d); chk("rr_peek_zero", d, 8'h00);
            exp_mem[i] = 8'h00;
        end
        scl = 1'b1; sda_m = 1'b1; wq(4);
        rstn = 1'b1; wq(8);

        // target works again after reset
        wr_burst(8'h02, 1, 8'hC3, 8'h00);
        rd_burst(8'h02, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
